nios_led_sequencer: RTL and testbench

Avalon-MM slave that owns the 5-bit LED port and sequences it. In manual mode it behaves as a plain output register. In run mode it steps through up to eight programmable pattern slots, holding each for a programmable dwell time, either once or looping. It sits on the Nios II data master and drives the board LEDs.

---
 rtl/nios_led_seq_pkg.sv | 32 +++
 rtl/nios_led_seq_timer.sv | 36 +++
 rtl/nios_led_sequencer.sv | 226 ++++++++++++++++++++++
 tb/tb_nios_led_sequencer.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nios_led_seq_pkg.sv
// nios_led_seq_pkg: shared constants and types for the LED sequencer.
// Holds the register map, CTRL/STATUS bit positions, bus widths and the
// sequencer state enum. Imported by nios_led_sequencer and nios_led_seq_timer.
package nios_led_seq_pkg;

    localparam int unsigned ADDR_W = 4;
    localparam int unsigned DATA_W = 32;

    // Word addresses
    localparam logic [ADDR_W-1:0] ADDR_DATA     = 4'd0;
    localparam logic [ADDR_W-1:0] ADDR_CTRL     = 4'd1;
    localparam logic [ADDR_W-1:0] ADDR_TICKS    = 4'd2;
    localparam logic [ADDR_W-1:0] ADDR_STATUS   = 4'd3;
    localparam logic [ADDR_W-1:0] ADDR_PAT_BASE = 4'd8;

    // CTRL bit positions
    localparam int unsigned CTRL_RUN_BIT    = 0;
    localparam int unsigned CTRL_LOOP_BIT   = 1;
    localparam int unsigned CTRL_IRQ_EN_BIT = 2;
    localparam int unsigned CTRL_LAST_LSB   = 4;

    // STATUS bit positions
    localparam int unsigned STAT_BUSY_BIT = 0;
    localparam int unsigned STAT_DONE_BIT = 1;
    localparam int unsigned STAT_SLOT_LSB = 4;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } seq_state_t;

endpackage

// File: rtl/nios_led_seq_timer.sv
// nios_led_seq_timer: dwell down-counter for the LED sequencer.
// Ports:
//   clk, reset_n   - clock, asynchronous active-low reset
//   load           - load load_value (has priority over enable)
//   enable         - decrement by one per cycle while non-zero
//   load_value     - reload value (TICKS register)
//   expire         - combinational, high when the count is zero
module nios_led_seq_timer
    import nios_led_seq_pkg::*;
#(
    parameter int unsigned TICK_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load,
    input  logic              enable,
    input  logic [TICK_W-1:0] load_value,
    output logic              expire
);

    logic [TICK_W-1:0] cnt;

    // Down counter; saturates at zero so expire stays asserted until reload
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_value;
        end else if (enable && (cnt != '0)) begin
            cnt <= cnt - TICK_W'(1);
        end
    end

    assign expire = (cnt == '0);

endmodule

// File: rtl/nios_led_sequencer.sv
// nios_led_sequencer: Avalon-MM slave owning the LED port.
// Manual mode drives out_port from the DATA register; run mode steps through
// programmable pattern slots PAT0..PAT[LAST], each held TICKS+1 cycles, once
// or looping. Optional completion interrupt under `define NIOS_LED_SEQ_IRQ_EN.
// Ports:
//   clk, reset_n                       - clock, asynchronous active-low reset
//   address, chipselect, write_n,
//   writedata                          - Avalon-MM slave write side
//   readdata                           - combinational read data, 0 wait states
//   out_port                           - registered LED drive
//   irq                                - level completion interrupt (macro only)
module nios_led_sequencer
    import nios_led_seq_pkg::*;
#(
    parameter int unsigned LED_W  = 5,
    parameter int unsigned SLOTS  = 8,
    parameter int unsigned TICK_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [DATA_W-1:0] writedata,
    output logic [DATA_W-1:0] readdata,
    output logic [LED_W-1:0]  out_port
`ifdef NIOS_LED_SEQ_IRQ_EN
    ,
    output logic              irq
`endif
);

    localparam int unsigned SLOT_W = $clog2(SLOTS);

    seq_state_t        state;
    logic [LED_W-1:0]  data_reg;
    logic [LED_W-1:0]  pat [SLOTS];
    logic [TICK_W-1:0] ticks;
    logic [SLOT_W-1:0] slot;
    logic [SLOT_W-1:0] ctrl_last;
    logic              ctrl_run;
    logic              ctrl_loop;
    logic              ctrl_irq_en;
    logic              done;

    // Address decode
    logic              wr;
    logic              wr_data;
    logic              wr_ctrl;
    logic              wr_ticks;
    logic              wr_status;
    logic [ADDR_W-1:0] pat_off;
    logic              pat_hit;
    logic [SLOT_W-1:0] pat_idx;
    logic              wr_pat;

    assign wr        = chipselect & ~write_n;
    assign wr_data   = wr && (address == ADDR_DATA);
    assign wr_ctrl   = wr && (address == ADDR_CTRL);
    assign wr_ticks  = wr && (address == ADDR_TICKS);
    assign wr_status = wr && (address == ADDR_STATUS);
    assign pat_off   = address - ADDR_PAT_BASE;
    assign pat_hit   = (address >= ADDR_PAT_BASE) && (pat_off < ADDR_W'(SLOTS));
    assign pat_idx   = pat_off[SLOT_W-1:0];
    assign wr_pat    = wr && pat_hit;

    // Sequencing decisions for this cycle
    logic              expire;
    logic              run_start;
    logic              run_stop;
    logic              step;
    logic              at_last;
    logic              advance;
    logic              wrap;
    logic              finish;
    logic [SLOT_W-1:0] slot_inc;
    logic [LED_W-1:0]  data_next;
    logic              done_next;

    assign run_start = wr_ctrl &&  writedata[CTRL_RUN_BIT];
    assign run_stop  = wr_ctrl && !writedata[CTRL_RUN_BIT];
    // A CTRL write owns the edge, so the dwell timer is ignored then
    assign step      = (state == RUN) && !wr_ctrl && expire;
    // LAST is compared live so software may shorten or extend a running sequence
    assign at_last   = (slot >= ctrl_last);
    assign advance   = step && !at_last;
    assign wrap      = step &&  at_last &&  ctrl_loop;
    assign finish    = step &&  at_last && !ctrl_loop;
    assign slot_inc  = slot + SLOT_W'(1);
    // A DATA write lands on the same edge as any return to IDLE
    assign data_next = wr_data ? writedata[LED_W-1:0] : data_reg;
    // Completion set wins over a simultaneous write-1-to-clear
    assign done_next = finish | (done & ~(wr_status & writedata[STAT_DONE_BIT]));

    nios_led_seq_timer #(
        .TICK_W (TICK_W)
    ) u_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (run_start | advance | wrap),
        .enable     (state == RUN),
        .load_value (ticks),
        .expire     (expire)
    );

    // Register file and sequencer FSM
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            out_port  <= '0;
            data_reg  <= '0;
            ticks     <= '0;
            slot      <= '0;
            ctrl_last <= '0;
            ctrl_run  <= 1'b0;
            ctrl_loop <= 1'b0;
            done      <= 1'b0;
            for (int i = 0; i < SLOTS; i++) begin
                pat[i] <= '0;
            end
        end else begin
            data_reg <= data_next;
            done     <= done_next;

            if (wr_ticks) begin
                ticks <= writedata[TICK_W-1:0];
            end
            if (wr_pat) begin
                pat[pat_idx] <= writedata[LED_W-1:0];
            end

            if (wr_ctrl) begin
                ctrl_run  <= writedata[CTRL_RUN_BIT];
                ctrl_loop <= writedata[CTRL_LOOP_BIT];
                ctrl_last <= writedata[CTRL_LAST_LSB +: SLOT_W];
            end else if (finish) begin
                ctrl_run  <= 1'b0;
            end

            if (run_start) begin
                state    <= RUN;
                slot     <= '0;
                out_port <= pat[0];
            end else if (run_stop) begin
                state    <= IDLE;
                out_port <= data_next;
            end else begin
                case (state)
                    IDLE: begin
                        out_port <= data_next;
                    end
                    RUN: begin
                        if (advance) begin
                            slot     <= slot_inc;
                            out_port <= pat[slot_inc];
                        end else if (wrap) begin
                            slot     <= '0;
                            out_port <= pat[0];
                        end else if (finish) begin
                            state    <= IDLE;
                            out_port <= data_next;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

`ifdef NIOS_LED_SEQ_IRQ_EN
    logic irq_en_next;

    assign irq_en_next = wr_ctrl ? writedata[CTRL_IRQ_EN_BIT] : ctrl_irq_en;

    // Interrupt enable and level interrupt tracking DONE
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_irq_en <= 1'b0;
            irq         <= 1'b0;
        end else begin
            ctrl_irq_en <= irq_en_next;
            irq         <= done_next & irq_en_next;
        end
    end
`else
    assign ctrl_irq_en = 1'b0;
`endif

    // Zero-wait-state read mux
    always_comb begin
        readdata = '0;
        if (pat_hit) begin
            readdata = DATA_W'(pat[pat_idx]);
        end else begin
            case (address)
                ADDR_DATA: begin
                    readdata = DATA_W'(out_port);
                end
                ADDR_CTRL: begin
                    readdata[CTRL_RUN_BIT]               = ctrl_run;
                    readdata[CTRL_LOOP_BIT]              = ctrl_loop;
                    readdata[CTRL_IRQ_EN_BIT]            = ctrl_irq_en;
                    readdata[CTRL_LAST_LSB +: SLOT_W]    = ctrl_last;
                end
                ADDR_TICKS: begin
                    readdata = DATA_W'(ticks);
                end
                ADDR_STATUS: begin
                    readdata[STAT_BUSY_BIT]              = (state == RUN);
                    readdata[STAT_DONE_BIT]              = done;
                    readdata[STAT_SLOT_LSB +: SLOT_W]    = slot;
                end
                default: begin
                    readdata = '0;
                end
            endcase
        end
    end

    // Upper writedata bits have no register behind them
    logic unused_wdata;
    assign unused_wdata = ^writedata;

endmodule

// File: tb/tb_nios_led_sequencer.sv
// tb_nios_led_sequencer: scoreboard bench for nios_led_sequencer.
// Stimulus pushes cycle-stamped expectations; a negedge monitor pops and
// compares out_port, readdata and irq for each stamped cycle.
module tb_nios_led_sequencer;

    localparam int K_OUT = 0;
    localparam int K_RD  = 1;
    localparam int K_IRQ = 2;

    logic        clk;
    logic        reset_n;
    logic [3:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [4:0]  out_port;
`ifdef NIOS_LED_SEQ_IRQ_EN
    logic        irq;
`endif

    nios_led_sequencer #(
        .LED_W  (5),
        .SLOTS  (8),
        .TICK_W (16)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port)
`ifdef NIOS_LED_SEQ_IRQ_EN
        ,
        .irq        (irq)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        int          kind;
        logic [31:0] exp;
        logic [31:0] mask;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Insert keeping the queue ordered by cycle stamp
    function automatic void expect_at(input int c, input int k, input logic [31:0] e,
                                      input logic [31:0] m, input string n);
        exp_t it;
        int   i;
        it.cyc  = c;
        it.kind = k;
        it.exp  = e;
        it.mask = m;
        it.name = n;
        i = 0;
        while (i < sb.size() && sb[i].cyc <= c) i++;
        sb.insert(i, it);
    endfunction

    // Monitor
    exp_t        mon_it;
    logic [31:0] mon_act;
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            mon_it = sb.pop_front();
            case (mon_it.kind)
                K_OUT:   mon_act = 32'(out_port);
                K_RD:    mon_act = readdata;
`ifdef NIOS_LED_SEQ_IRQ_EN
                K_IRQ:   mon_act = 32'(irq);
`endif
                default: mon_act = 32'hDEAD_BEEF;
            endcase
            checks++;
            if (mon_it.cyc != cyc) begin
                errors++;
                $display("FAIL %s: sampled at cycle %0d, required cycle %0d",
                         mon_it.name, cyc, mon_it.cyc);
            end else if ((mon_act & mon_it.mask) != (mon_it.exp & mon_it.mask)) begin
                errors++;
                $display("FAIL %s: cycle %0d got 0x%08h expected 0x%08h",
                         mon_it.name, cyc, mon_act & mon_it.mask, mon_it.exp & mon_it.mask);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) tick();
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    task automatic rd(input logic [3:0] a, input logic [31:0] e, input logic [31:0] m,
                      input string n);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        expect_at(cyc, K_RD, e, m, n);
        tick();
        chipselect = 1'b0;
    endtask

    localparam logic [31:0] ALL = 32'hFFFF_FFFF;

    initial begin
        int e;
        int f;
        int guard;

        reset_n    = 1'b0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = '0;
        writedata  = '0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Reset state
        expect_at(cyc, K_OUT, 0, ALL, "rst_out");
`ifdef NIOS_LED_SEQ_IRQ_EN
        expect_at(cyc, K_IRQ, 0, ALL, "rst_irq");
`endif
        rd(4'd0, 32'h0, ALL, "rst_data");
        rd(4'd1, 32'h0, ALL, "rst_ctrl");
        rd(4'd2, 32'h0, ALL, "rst_ticks");
        rd(4'd3, 32'h0, ALL, "rst_status");

        // Manual mode, upper write bits dropped
        wr(4'd0, 32'hABCD_EFF5);
        expect_at(cyc, K_OUT, 32'h15, ALL, "manual_out");
        rd(4'd0, 32'h0000_0015, ALL, "manual_rd");

        // Unmapped space
        wr(4'd4, ALL);
        rd(4'd4, 32'h0, ALL, "unmapped4");
        rd(4'd7, 32'h0, ALL, "unmapped7");
        expect_at(cyc, K_OUT, 32'h15, ALL, "unmapped_out");

        // One-shot: 3 slots x 4 cycles
        wr(4'd8, 32'h01);
        wr(4'd9, 32'h02);
        wr(4'd10, 32'h04);
        wr(4'd2, 32'd3);
        rd(4'd9, 32'h02, ALL, "pat1_rd");
        rd(4'd2, 32'h03, ALL, "ticks_rd");
        wr(4'd1, 32'h21);
        e = cyc;
        for (int i = 0; i < 12; i++)
            expect_at(e + i, K_OUT, 32'(1 << (i / 4)), ALL, "oneshot_out");
        expect_at(e + 12, K_OUT, 32'h15, ALL, "oneshot_end_out");
        rd(4'd3, 32'h01, ALL, "oneshot_status_s0");
        wait_cyc(e + 5);
        rd(4'd3, 32'h11, ALL, "oneshot_status_s1");
        wait_cyc(e + 12);
        rd(4'd3, 32'h22, ALL, "oneshot_done");
        rd(4'd1, 32'h20, ALL, "oneshot_ctrl");
        rd(4'd0, 32'h15, ALL, "oneshot_data");
        wr(4'd3, 32'h2);
        rd(4'd3, 32'h20, ALL, "done_clear");

        // Loop every cycle, then software abort
        wr(4'd2, 32'd0);
        wr(4'd1, 32'h13);
        e = cyc;
        for (int i = 0; i < 7; i++)
            expect_at(e + i, K_OUT, (i % 2 == 1) ? 32'h02 : 32'h01, ALL, "loop_out");
        rd(4'd3, 32'h01, ALL, "loop_status_s0");
        rd(4'd3, 32'h11, ALL, "loop_status_s1");
        wait_cyc(e + 6);
        wr(4'd1, 32'h0);
        expect_at(cyc, K_OUT, 32'h15, ALL, "abort_out");
        rd(4'd3, 32'h0, 32'h3, "abort_status");

        // Mid-dwell pattern write
        wr(4'd2, 32'd3);
        wr(4'd1, 32'h13);
        e = cyc;
        for (int i = 0; i < 17; i++)
            expect_at(e + i, K_OUT,
                      ((i / 4) % 2 == 1) ? ((i >= 12) ? 32'h1C : 32'h02) : 32'h01,
                      ALL, "middwell_out");
        wait_cyc(e + 5);
        wr(4'd9, 32'h1C);
        wait_cyc(e + 16);
        wr(4'd1, 32'h0);
        expect_at(cyc, K_OUT, 32'h15, ALL, "middwell_abort_out");
        rd(4'd9, 32'h1C, ALL, "middwell_pat1_rd");

`ifdef NIOS_LED_SEQ_IRQ_EN
        // Completion interrupt and W1C
        wr(4'd2, 32'd0);
        wr(4'd1, 32'h25);
        e = cyc;
        for (int i = 0; i < 3; i++)
            expect_at(e + i, K_IRQ, 0, ALL, "irq_low_run");
        expect_at(e,     K_OUT, 32'h01, ALL, "irq_run_out0");
        expect_at(e + 1, K_OUT, 32'h1C, ALL, "irq_run_out1");
        expect_at(e + 2, K_OUT, 32'h04, ALL, "irq_run_out2");
        expect_at(e + 3, K_OUT, 32'h15, ALL, "irq_end_out");
        expect_at(e + 3, K_IRQ, 1, ALL, "irq_set");
        wait_cyc(e + 3);
        rd(4'd1, 32'h24, ALL, "irq_ctrl");
        wr(4'd3, 32'h2);
        expect_at(cyc, K_IRQ, 0, ALL, "irq_clear");

        // Clear collides with completion: set wins
        wr(4'd1, 32'h25);
        f = cyc;
        wait_cyc(f + 2);
        wr(4'd3, 32'h2);
        expect_at(cyc, K_IRQ, 1, ALL, "collide_irq");
        rd(4'd3, 32'h2, 32'h3, "collide_done");
        wr(4'd3, 32'h2);
        expect_at(cyc, K_IRQ, 0, ALL, "collide_clear_irq");
        rd(4'd3, 32'h0, 32'h3, "collide_clear_done");
`else
        // CTRL bit2 ignores writes and reads 0
        wr(4'd1, 32'h24);
        rd(4'd1, 32'h20, ALL, "irq_en_absent");
`endif

        // Asynchronous reset mid-run
        wr(4'd2, 32'd3);
        wr(4'd1, 32'h13);
        e = cyc;
        expect_at(e, K_OUT, 32'h01, ALL, "prereset_out");
        wait_cyc(e + 2);
        address    = 4'd3;
        chipselect = 1'b1;
        write_n    = 1'b1;
        reset_n    = 1'b0;
        expect_at(cyc, K_OUT, 0, ALL, "async_rst_out");
        expect_at(cyc, K_RD, 0, ALL, "async_rst_status");
`ifdef NIOS_LED_SEQ_IRQ_EN
        expect_at(cyc, K_IRQ, 0, ALL, "async_rst_irq");
`endif
        tick();
        chipselect = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        expect_at(cyc, K_OUT, 0, ALL, "post_rst_out");
        rd(4'd0, 32'h0, ALL, "post_rst_data");
        rd(4'd1, 32'h0, ALL, "post_rst_ctrl");
        rd(4'd3, 32'h0, ALL, "post_rst_status");
        rd(4'd9, 32'h0, ALL, "post_rst_pat1");

        // Drain the scoreboard with a bound
        guard = 0;
        while (sb.size() > 0 && guard < 100) begin
            tick();
            guard++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d pending, required 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
